// File: rtl/muldiv_seq_if.sv
// Handshake and result bus between the EXE stage (master) and the
// multiply/divide sequencer (slave).
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             accept;
    logic             flush;
    logic             finish;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, data0, data1, accept, flush,
        input  finish, busy, hi, lo
    );

    modport slave (
        input  start, op, data0, data1, accept, flush,
        output finish, busy, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 sequential multiply / restoring divide with HI/LO registers that
// commit only when the pipeline accepts the instruction.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         resetn,
    muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [2:0]             op_reg;
    logic [CW-1:0]          count_reg;
    logic [WIDTH-1:0]       a_reg;
    logic [2*WIDTH-1:0]     acc_reg;
    logic                   sign0_reg, sign1_reg;
    logic                   wr_hi_reg, wr_lo_reg;
    logic [WIDTH-1:0]       pend_hi_reg, pend_lo_reg;
    logic [WIDTH-1:0]       hi_reg, lo_reg;

    // Decode of the incoming request
    logic             in_signed, in_mul, in_div, in_div_zero;
    logic [WIDTH-1:0] mag0, mag1;
    logic             launch, go_busy, commit;

    assign in_signed   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign in_mul      = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign in_div      = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign in_div_zero = in_div && (bus.data1 == '0);
    assign mag0        = (in_signed && bus.data0[WIDTH-1]) ? -bus.data0 : bus.data0;
    assign mag1        = (in_signed && bus.data1[WIDTH-1]) ? -bus.data1 : bus.data1;
    assign launch      = (state_reg == IDLE) && bus.start && !bus.flush;
    assign go_busy     = launch && (in_mul || (in_div && !in_div_zero));
    assign commit      = (state_reg == DONE) && bus.accept && !bus.flush;

    // Multiply step: conditional add into the upper half, then shift right
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = a_reg[gi] & acc_reg[0];
        end
    endgenerate

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide step: the remainder never exceeds the divisor, so one extra bit
    // holds the shifted value and the borrow bit decides the quotient bit.
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;

    assign rem_sh   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, a_reg};
    assign div_ge   = ~rem_diff[WIDTH];
    assign rem_new  = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_next = {rem_new, acc_reg[WIDTH-2:0], div_ge};

    logic               is_mul_reg, neg_res;
    logic [2*WIDTH-1:0] iter_next, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign is_mul_reg = (op_reg == OP_MULT) || (op_reg == OP_MULTU);
    assign iter_next  = is_mul_reg ? mul_next : div_next;
    assign neg_res    = sign0_reg ^ sign1_reg;
    assign prod_fix   = neg_res ? -mul_next : mul_next;
    assign quot_fix   = neg_res ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign rem_fix    = sign0_reg ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        bus.finish = 1'b0;
        bus.busy   = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.finish = !bus.start;
                if (launch) state_next = go_busy ? BUSY : DONE;
            end
            BUSY: begin
                bus.busy = 1'b1;
                if (count_reg == '0) state_next = DONE;
            end
            DONE: begin
                bus.finish = 1'b1;
                if (bus.accept) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_reg      <= '0;
            count_reg   <= '0;
            a_reg       <= '0;
            acc_reg     <= '0;
            sign0_reg   <= 1'b0;
            sign1_reg   <= 1'b0;
            wr_hi_reg   <= 1'b0;
            wr_lo_reg   <= 1'b0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            if (launch) begin
                op_reg    <= bus.op;
                count_reg <= CW'(WIDTH - 1);
                sign0_reg <= in_signed && bus.data0[WIDTH-1];
                sign1_reg <= in_signed && bus.data1[WIDTH-1];
                wr_hi_reg <= 1'b0;
                wr_lo_reg <= 1'b0;
                if (in_mul) begin
                    a_reg     <= mag0;
                    acc_reg   <= {{WIDTH{1'b0}}, mag1};
                    wr_hi_reg <= 1'b1;
                    wr_lo_reg <= 1'b1;
                end else if (in_div) begin
                    a_reg     <= mag1;
                    acc_reg   <= {{WIDTH{1'b0}}, mag0};
                    wr_hi_reg <= 1'b1;
                    wr_lo_reg <= 1'b1;
                    if (in_div_zero) begin
                        pend_hi_reg <= bus.data0;
                        pend_lo_reg <= '1;
                    end
                end else if (bus.op == OP_MTHI) begin
                    pend_hi_reg <= bus.data0;
                    wr_hi_reg   <= 1'b1;
                end else if (bus.op == OP_MTLO) begin
                    pend_lo_reg <= bus.data0;
                    wr_lo_reg   <= 1'b1;
                end
            end else if (state_reg == BUSY) begin
                acc_reg <= iter_next;
                if (count_reg != '0) begin
                    count_reg <= count_reg - 1'b1;
                end else if (is_mul_reg) begin
                    pend_hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                    pend_lo_reg <= prod_fix[WIDTH-1:0];
                end else begin
                    pend_hi_reg <= rem_fix;
                    pend_lo_reg <= quot_fix;
                end
            end
            if (commit) begin
                if (wr_hi_reg) hi_reg <= pend_hi_reg;
                if (wr_lo_reg) lo_reg <= pend_lo_reg;
            end
        end
    end

    assign bus.hi = hi_reg;
    assign bus.lo = lo_reg;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq against an arithmetic model
// of HI/LO, latency and the stall/accept handshake.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Architectural result of one instruction given the current HI/LO
    task automatic model(input logic [2:0] op, input logic [31:0] d0, input logic [31:0] d1,
                         output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0]        up;
        h  = m_hi;
        l  = m_lo;
        sa = {{32{d0[31]}}, d0};
        sb = {{32{d1[31]}}, d1};
        case (op)
            3'd0: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
            3'd1: begin up = {32'b0, d0} * {32'b0, d1}; h = up[63:32]; l = up[31:0]; end
            3'd2: begin
                if (d1 == 0) begin l = 32'hFFFF_FFFF; h = d0; end
                else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
            end
            3'd3: begin
                if (d1 == 0) begin l = 32'hFFFF_FFFF; h = d0; end
                else begin l = d0 / d1; h = d0 % d1; end
            end
            3'd4: h = d0;
            3'd5: l = d0;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] d0, input logic [31:0] d1,
                          input int hold);
        int          lat;
        int          exp_lat;
        logic [31:0] nh, nl;
        exp_lat = (op <= 3 && !(op >= 2 && d1 == 0)) ? 33 : 1;
        model(op, d0, d1, nh, nl);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.data0 = d0;
        bus.data1 = d1;
        #1 check("finish_low_at_start", 64'(bus.finish), 64'd0);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (lat == 1) check("busy_after_start", 64'(bus.busy), 64'(exp_lat == 33));
            if (bus.finish) break;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        for (int k = 0; k < hold; k++) begin
            check("hi_before_accept", 64'(bus.hi), 64'(m_hi));
            check("lo_before_accept", 64'(bus.lo), 64'(m_lo));
            check("finish_in_done", 64'(bus.finish), 64'd1);
            check("no_restart", 64'(bus.busy), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.accept = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.accept = 1'b0;
        bus.start  = 1'b0;
        m_hi = nh;
        m_lo = nl;
        #1;
        check("hi_commit", 64'(bus.hi), 64'(m_hi));
        check("lo_commit", 64'(bus.lo), 64'(m_lo));
        check("finish_idle", 64'(bus.finish), 64'd1);
        $display("op=%0d d0=%h d1=%h hold=%0d lat=%0d hi=%h lo=%h",
                 op, d0, d1, hold, lat, bus.hi, bus.lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] rd0, rd1;

        resetn     = 1'b0;
        bus.start  = 1'b0;
        bus.op     = '0;
        bus.data0  = '0;
        bus.data1  = '0;
        bus.accept = 1'b0;
        bus.flush  = 1'b0;
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_finish", 64'(bus.finish), 64'd1);
        bus.start = 1'b1;
        #1 check("reset_finish_start", 64'(bus.finish), 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1);
        run_op(3'd3, 32'd100, 32'd0, 0);
        run_op(3'd5, 32'h1234_5678, 32'd0, 0);
        run_op(3'd3, 32'd1000, 32'd7, 5);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FF00, 32'd0, 0);
        run_op(3'd4, 32'hCAFE_F00D, 32'd0, 2);
        run_op(3'd6, 32'h1111_1111, 32'h2222_2222, 0);

        // Flush a multiply mid-iteration
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.data0 = 32'h0001_2345;
        bus.data1 = 32'hFFFF_0001;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        #1;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_finish", 64'(bus.finish), 64'd1);
        check("flush_hi", 64'(bus.hi), 64'(m_hi));
        check("flush_lo", 64'(bus.lo), 64'(m_lo));
        $display("flush mid-MULT hi=%h lo=%h", bus.hi, bus.lo);
        run_op(3'd1, 32'h0000_FFFF, 32'h0001_0001, 0);

        // Asynchronous reset between edges while busy
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd3;
        bus.data0 = 32'd12345;
        bus.data1 = 32'd17;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        resetn    = 1'b0;
        bus.start = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_hi", 64'(bus.hi), 64'd0);
        check("arst_lo", 64'(bus.lo), 64'd0);
        check("arst_finish", 64'(bus.finish), 64'd1);
        $display("async reset mid-DIVU hi=%h lo=%h", bus.hi, bus.lo);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            rd0 = $urandom;
            rd1 = $urandom;
            case ($urandom_range(0, 5))
                0: rd1 = '0;
                1: rd1 = 32'($urandom_range(1, 20));
                2: rd0 = 32'h8000_0000;
                3: rd1 = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(rop, rd0, rd1, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
